// File: rtl/tft_pkg.sv
// Shared constants for the TFT command sequencer: panel register indices,
// oCall bit positions and the sequencer state encoding.
package tft_pkg;

  localparam logic [7:0] R_XADDR  = 8'h4E;
  localparam logic [7:0] R_YADDR  = 8'h4F;
  localparam logic [7:0] R_GRAM   = 8'h22;
  localparam logic [7:0] R_HWIN   = 8'h44;
  localparam logic [7:0] R_VWIN_S = 8'h45;
  localparam logic [7:0] R_VWIN_E = 8'h46;

  localparam int CALL_REG  = 2;
  localparam int CALL_IDX  = 1;
  localparam int CALL_DATA = 0;

  localparam int ROM_AW = 6;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_CLIP,
    S_WIN,
    S_ROW,
    S_IDX,
    S_PIX,
    S_RESTORE,
    S_DONE,
    S_WAIT_REL
  } tft_state_e;

  function automatic logic [2:0] call_bit(input int pos);
    return 3'(1 << pos);
  endfunction

endpackage

// File: rtl/tft_init_rom.sv
// Panel power-up register table: index -> {register[7:0], value[15:0]}.
// Covers oscillator, power, display control, window, gamma and cursor home.
module tft_init_rom
  import tft_pkg::*;
(
  input  logic [ROM_AW-1:0] idx,
  output logic [7:0]        addr,
  output logic [15:0]       data
);

  logic [23:0] entry;

  always_comb begin
    entry = 24'h00_0000;
    case (idx)
      6'd0:  entry = 24'h00_0001;
      6'd1:  entry = 24'h03_A8A4;
      6'd2:  entry = 24'h0C_0000;
      6'd3:  entry = 24'h0D_080C;
      6'd4:  entry = 24'h0E_2B00;
      6'd5:  entry = 24'h1E_00B7;
      6'd6:  entry = 24'h01_2B3F;
      6'd7:  entry = 24'h02_0600;
      6'd8:  entry = 24'h10_0000;
      6'd9:  entry = 24'h11_6070;
      6'd10: entry = 24'h05_0000;
      6'd11: entry = 24'h06_0000;
      6'd12: entry = 24'h16_EF1C;
      6'd13: entry = 24'h17_0003;
      6'd14: entry = 24'h07_0233;
      6'd15: entry = 24'h0B_0000;
      6'd16: entry = 24'h0F_0000;
      6'd17: entry = 24'h41_0000;
      6'd18: entry = 24'h42_0000;
      6'd19: entry = 24'h48_0000;
      6'd20: entry = 24'h49_013F;
      6'd21: entry = 24'h4A_0000;
      6'd22: entry = 24'h4B_0000;
      6'd23: entry = 24'h44_EF00;
      6'd24: entry = 24'h45_0000;
      6'd25: entry = 24'h46_013F;
      6'd26: entry = 24'h30_0707;
      6'd27: entry = 24'h31_0204;
      6'd28: entry = 24'h32_0204;
      6'd29: entry = 24'h33_0502;
      6'd30: entry = 24'h34_0507;
      6'd31: entry = 24'h35_0204;
      6'd32: entry = 24'h36_0204;
      6'd33: entry = 24'h37_0502;
      6'd34: entry = 24'h3A_0302;
      6'd35: entry = 24'h3B_0302;
      6'd36: entry = 24'h23_0000;
      6'd37: entry = 24'h4E_0000;
      6'd38: entry = 24'h4F_0000;
      default: entry = 24'h00_0000;
    endcase
  end

  assign addr = entry[23:16];
  assign data = entry[15:0];

endmodule

// File: rtl/tft_fillmod.sv
// TFT command sequencer: panel init, full-screen clear and clipped rectangle fill.
// Define TFT_WINDOW_EN to fill through the panel's hardware window instead of per-row cursor writes.
module tft_fillmod
  import tft_pkg::*;
#(
  parameter int H_RES    = 240,
  parameter int V_RES    = 320,
  parameter int XW       = 8,
  parameter int YW       = 9,
  parameter int INIT_LEN = 39
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic [2:0]    iCall,
  output logic          oDone,
  input  logic [XW-1:0] iX,
  input  logic [YW-1:0] iY,
  input  logic [XW-1:0] iW,
  input  logic [YW-1:0] iH,
  input  logic [15:0]   iColor,
  output logic [2:0]    oCall,
  input  logic          iDone,
  output logic [7:0]    oAddr,
  output logic [15:0]   oData,
  output tft_state_e    dbg_state
);

  localparam int PW = $clog2(H_RES * V_RES + 1);

  // Handshake: a command is one oCall bit plus oAddr/oData, held until iDone is
  // sampled; oCall then drops for at least one cycle before the next command.
  tft_state_e state_q, state_d;
  logic [XW-1:0] x_q, x_d, w_q, w_d, xe_q, xe_d;
  logic [YW-1:0] y_q, y_d, h_q, h_d, ye_q, ye_d, row_q, row_d;
  logic [15:0]   color_q, color_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [ROM_AW-1:0] idx_q, idx_d;
  logic [1:0]    sub_q, sub_d;
  logic [2:0]    call_q, call_d;
  logic [7:0]    addr_q, addr_d;
  logic [15:0]   data_q, data_d;
  logic          done_q, done_d;

  logic          ack, cmd_go;
  logic [2:0]    cmd_call;
  logic [7:0]    cmd_addr;
  logic [15:0]   cmd_data;
  logic [7:0]    rom_addr;
  logic [15:0]   rom_data;
  logic [XW:0]   x_sum, x_end;
  logic [YW:0]   y_sum, y_end;
  logic          degenerate;
  logic [PW-1:0] cols;
`ifdef TFT_WINDOW_EN
  logic [PW-1:0] rows;
`endif

  tft_init_rom u_rom (
    .idx  (idx_q),
    .addr (rom_addr),
    .data (rom_data)
  );

  // Clip end coordinates are computed one bit wider so X+W cannot wrap.
  assign x_sum = {1'b0, x_q} + {1'b0, w_q};
  assign y_sum = {1'b0, y_q} + {1'b0, h_q};
  assign x_end = (x_sum > (XW+1)'(H_RES)) ? (XW+1)'(H_RES) : x_sum;
  assign y_end = (y_sum > (YW+1)'(V_RES)) ? (YW+1)'(V_RES) : y_sum;
  assign degenerate = (w_q == '0) || (h_q == '0) ||
                      ({1'b0, x_q} >= (XW+1)'(H_RES)) ||
                      ({1'b0, y_q} >= (YW+1)'(V_RES));
  assign cols = PW'(xe_q) - PW'(x_q) + PW'(1);
`ifdef TFT_WINDOW_EN
  assign rows = PW'(ye_q) - PW'(y_q) + PW'(1);
`endif

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    w_d      = w_q;
    h_d      = h_q;
    color_d  = color_q;
    xe_d     = xe_q;
    ye_d     = ye_q;
    row_d    = row_q;
    pix_d    = pix_q;
    idx_d    = idx_q;
    sub_d    = sub_q;
    call_d   = call_q;
    addr_d   = addr_q;
    data_d   = data_q;
    cmd_go   = 1'b0;
    cmd_call = 3'b000;
    cmd_addr = 8'h00;
    cmd_data = 16'h0000;
    ack      = (call_q != 3'b000) && iDone;

    case (state_q)
      S_IDLE: begin
        if (iCall[0]) begin
          idx_d   = '0;
          state_d = S_INIT;
        end else if (iCall[1]) begin
          x_d     = '0;
          y_d     = '0;
          w_d     = XW'(H_RES);
          h_d     = YW'(V_RES);
          color_d = iColor;
          state_d = S_CLIP;
        end else if (iCall[2]) begin
          x_d     = iX;
          y_d     = iY;
          w_d     = iW;
          h_d     = iH;
          color_d = iColor;
          state_d = S_CLIP;
        end
      end
      S_INIT: begin
        cmd_go   = 1'b1;
        cmd_call = call_bit(CALL_REG);
        cmd_addr = rom_addr;
        cmd_data = rom_data;
        if (ack) begin
          if (idx_q == ROM_AW'(INIT_LEN - 1)) state_d = S_DONE;
          else idx_d = idx_q + 1'b1;
        end
      end
      S_CLIP: begin
        xe_d  = XW'(x_end - 1'b1);
        ye_d  = YW'(y_end - 1'b1);
        row_d = y_q;
        sub_d = 2'd0;
        if (degenerate) state_d = S_DONE;
`ifdef TFT_WINDOW_EN
        else state_d = S_WIN;
`else
        else state_d = S_ROW;
`endif
      end
`ifdef TFT_WINDOW_EN
      S_WIN: begin
        cmd_go   = 1'b1;
        cmd_call = call_bit(CALL_REG);
        case (sub_q)
          2'd0:    begin cmd_addr = R_HWIN;   cmd_data = {8'(xe_q), 8'(x_q)}; end
          2'd1:    begin cmd_addr = R_VWIN_S; cmd_data = 16'(y_q); end
          default: begin cmd_addr = R_VWIN_E; cmd_data = 16'(ye_q); end
        endcase
        if (ack) begin
          if (sub_q == 2'd2) begin
            sub_d   = 2'd0;
            state_d = S_ROW;
          end else sub_d = sub_q + 1'b1;
        end
      end
      S_RESTORE: begin
        cmd_go   = 1'b1;
        cmd_call = call_bit(CALL_REG);
        case (sub_q)
          2'd0:    begin cmd_addr = R_HWIN;   cmd_data = {8'(H_RES - 1), 8'h00}; end
          2'd1:    begin cmd_addr = R_VWIN_S; cmd_data = 16'h0000; end
          default: begin cmd_addr = R_VWIN_E; cmd_data = 16'(V_RES - 1); end
        endcase
        if (ack) begin
          if (sub_q == 2'd2) state_d = S_DONE;
          else sub_d = sub_q + 1'b1;
        end
      end
`endif
      S_ROW: begin
        cmd_go   = 1'b1;
        cmd_call = call_bit(CALL_REG);
        if (sub_q == 2'd0) begin
          cmd_addr = R_XADDR;
          cmd_data = 16'(x_q);
        end else begin
          cmd_addr = R_YADDR;
          cmd_data = 16'(row_q);
        end
        if (ack) begin
          if (sub_q == 2'd0) sub_d = 2'd1;
          else begin
            sub_d   = 2'd0;
            state_d = S_IDX;
          end
        end
      end
      S_IDX: begin
        cmd_go   = 1'b1;
        cmd_call = call_bit(CALL_IDX);
        cmd_addr = R_GRAM;
        if (ack) begin
`ifdef TFT_WINDOW_EN
          pix_d = cols * rows - PW'(1);
`else
          pix_d = cols - PW'(1);
`endif
          state_d = S_PIX;
        end
      end
      S_PIX: begin
        cmd_go   = 1'b1;
        cmd_call = call_bit(CALL_DATA);
        cmd_data = color_q;
        // pix_q counts down the pixels still owed after the one in flight.
        if (ack) begin
          if (pix_q != '0) pix_d = pix_q - 1'b1;
`ifdef TFT_WINDOW_EN
          else begin
            sub_d   = 2'd0;
            state_d = S_RESTORE;
          end
`else
          else if (row_q < ye_q) begin
            row_d   = row_q + 1'b1;
            state_d = S_ROW;
          end else state_d = S_DONE;
`endif
        end
      end
      S_DONE: state_d = S_WAIT_REL;
      S_WAIT_REL: begin
        if (iCall == 3'b000) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (call_q == 3'b000) begin
      if (cmd_go) begin
        call_d = cmd_call;
        addr_d = cmd_addr;
        data_d = cmd_data;
      end
    end else if (iDone) begin
      call_d = 3'b000;
    end

    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
      xe_q    <= '0;
      ye_q    <= '0;
      row_q   <= '0;
      pix_q   <= '0;
      idx_q   <= '0;
      sub_q   <= '0;
      call_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      color_q <= color_d;
      xe_q    <= xe_d;
      ye_q    <= ye_d;
      row_q   <= row_d;
      pix_q   <= pix_d;
      idx_q   <= idx_d;
      sub_q   <= sub_d;
      call_q  <= call_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign oCall     = call_q;
  assign oAddr     = addr_q;
  assign oData     = data_q;
  assign oDone     = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tft_fillmod.sv
// Directed bench for tft_fillmod: a lower-level responder acks each command three
// cycles after it appears and logs it; each step compares the log with hand-built lists.
module tb_tft_fillmod;
  import tft_pkg::*;

  localparam int XW = 8;
  localparam int YW = 9;
  localparam int ACK_LAT = 3;
  localparam logic [2:0] C_REG  = 3'b100;
  localparam logic [2:0] C_IDX  = 3'b010;
  localparam logic [2:0] C_DATA = 3'b001;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    i_call = 3'b000;
  logic          o_done;
  logic [XW-1:0] i_x = '0, i_w = '0;
  logic [YW-1:0] i_y = '0, i_h = '0;
  logic [15:0]   i_color = '0;
  logic [2:0]    o_call;
  logic          i_done = 1'b0;
  logic [7:0]    o_addr;
  logic [15:0]   o_data;
  tft_state_e    dbg_state;

  always #5 clk = ~clk;

  tft_fillmod dut (
    .CLOCK     (clk),
    .RESET     (rst),
    .iCall     (i_call),
    .oDone     (o_done),
    .iX        (i_x),
    .iY        (i_y),
    .iW        (i_w),
    .iH        (i_h),
    .iColor    (i_color),
    .oCall     (o_call),
    .iDone     (i_done),
    .oAddr     (o_addr),
    .oData     (o_data),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [26:0] exp_q[$];
  logic [26:0] obs_q[$];
  int done_cnt = 0;
  int hs_viol  = 0;

  // Responder and bus monitor: addr is masked on data writes, data on index writes.
  int          ack_cnt = 0;
  logic        prev_valid = 1'b0;
  logic [26:0] prev_cmd = '0;
  always @(negedge clk) begin
    logic [26:0] cur;
    cur = {o_call, (o_call[0] ? 8'h00 : o_addr), (o_call[1] ? 16'h0000 : o_data)};
    if (rst) begin
      i_done = 1'b0;
      ack_cnt = 0;
      prev_valid = 1'b0;
    end else begin
      if (o_done) done_cnt++;
      if (o_call != 3'b000 && !$onehot(o_call)) hs_viol++;
      if (prev_valid) begin
        if (i_done) begin
          if (o_call != 3'b000) hs_viol++;
        end else if (cur != prev_cmd) hs_viol++;
      end
      if (i_done) begin
        i_done = 1'b0;
        ack_cnt = 0;
      end else if (o_call != 3'b000) begin
        if (ack_cnt == ACK_LAT - 1) begin
          i_done = 1'b1;
          obs_q.push_back(cur);
        end else ack_cnt++;
      end else ack_cnt = 0;
      prev_valid = (o_call != 3'b000);
      prev_cmd = cur;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_cmd(input logic [2:0] c, input logic [7:0] a, input logic [15:0] d);
    exp_q.push_back({c, a, d});
  endtask

  // Expected bus traffic for a fill whose clipped extent is x..xe, y..ye.
  task automatic push_fill(input int x, input int y, input int xe, input int ye, input logic [15:0] col);
`ifdef TFT_WINDOW_EN
    push_cmd(C_REG, 8'h44, 16'((xe << 8) | x));
    push_cmd(C_REG, 8'h45, 16'(y));
    push_cmd(C_REG, 8'h46, 16'(ye));
    push_cmd(C_REG, 8'h4E, 16'(x));
    push_cmd(C_REG, 8'h4F, 16'(y));
    push_cmd(C_IDX, 8'h22, 16'h0000);
    repeat ((xe - x + 1) * (ye - y + 1)) push_cmd(C_DATA, 8'h00, col);
    push_cmd(C_REG, 8'h44, 16'hEF00);
    push_cmd(C_REG, 8'h45, 16'h0000);
    push_cmd(C_REG, 8'h46, 16'h013F);
`else
    for (int r = y; r <= ye; r++) begin
      push_cmd(C_REG, 8'h4E, 16'(x));
      push_cmd(C_REG, 8'h4F, 16'(r));
      push_cmd(C_IDX, 8'h22, 16'h0000);
      repeat (xe - x + 1) push_cmd(C_DATA, 8'h00, col);
    end
`endif
  endtask

  task automatic compare_log(input string tag, input bit full);
    int n;
    n = exp_q.size();
    if (full) check({tag, " count"}, 32'(obs_q.size()), 32'(n));
    if (obs_q.size() < n) n = obs_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s cmd%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic start_op(input logic [2:0] c, input int x, input int y, input int w, input int h,
                          input logic [15:0] col);
    i_x = XW'(x);
    i_y = YW'(y);
    i_w = XW'(w);
    i_h = YW'(h);
    i_color = col;
    done_cnt = 0;
    hs_viol = 0;
    i_call = c;
  endtask

  task automatic wait_done(input string tag, input int budget, output int cyc);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (o_done) break;
      if (cyc >= budget) begin
        check({tag, " done timeout"}, 32'(cyc), 32'(0));
        break;
      end
    end
  endtask

  task automatic release_req();
    i_call = 3'b000;
    tick(3);
  endtask

  int cyc;
  int data_n;

  initial begin
    tick(3);
    check("reset oCall", 32'(o_call), 32'(0));
    check("reset oDone", 32'(o_done), 32'(0));
    check("reset oAddr", 32'(o_addr), 32'(0));
    check("reset oData", 32'(o_data), 32'(0));
    check("reset state", 32'(dbg_state), 32'(S_IDLE));
    rst = 1'b0;
    tick(2);

    // Panel init from the register table
    start_op(3'b001, 0, 0, 0, 0, 16'h0000);
    wait_done("init", 3000, cyc);
    check("init count", 32'(obs_q.size()), 32'(39));
    if (obs_q.size() == 39) begin
      check("init first", 32'(obs_q[0]), 32'({C_REG, 8'h00, 16'h0001}));
      check("init 4E", 32'(obs_q[37]), 32'({C_REG, 8'h4E, 16'h0000}));
      check("init last", 32'(obs_q[38]), 32'({C_REG, 8'h4F, 16'h0000}));
    end
    data_n = 0;
    foreach (obs_q[i]) if (obs_q[i][26:24] != C_REG) data_n++;
    check("init non-reg cmds", 32'(data_n), 32'(0));
    obs_q.delete();
    release_req();
    check("init done pulses", 32'(done_cnt), 32'(1));
    check("init handshake", 32'(hs_viol), 32'(0));

    // Rectangle fill fully on-screen
    start_op(3'b100, 10, 20, 4, 3, 16'hF800);
    push_fill(10, 20, 13, 22, 16'hF800);
    wait_done("rect", 3000, cyc);
    data_n = 0;
    foreach (obs_q[i]) if (obs_q[i][26:24] == C_DATA) data_n++;
    check("rect data writes", 32'(data_n), 32'(12));
    compare_log("rect", 1'b1);
    release_req();
    check("rect done pulses", 32'(done_cnt), 32'(1));
    check("rect handshake", 32'(hs_viol), 32'(0));

    // Rectangle clipped at the bottom-right corner
    start_op(3'b100, 238, 318, 10, 10, 16'h07E0);
    push_fill(238, 318, 239, 319, 16'h07E0);
    wait_done("clip", 3000, cyc);
    compare_log("clip", 1'b1);
    release_req();
    check("clip handshake", 32'(hs_viol), 32'(0));

    // Degenerate requests finish without bus traffic
    start_op(3'b100, 5, 5, 0, 4, 16'hFFFF);
    wait_done("w0", 20, cyc);
    check("w0 latency", 32'(cyc), 32'(2));
    check("w0 bus idle", 32'(obs_q.size()), 32'(0));
    obs_q.delete();
    release_req();
    start_op(3'b100, 240, 5, 3, 4, 16'hFFFF);
    wait_done("x240", 20, cyc);
    check("x240 latency", 32'(cyc), 32'(2));
    check("x240 bus idle", 32'(obs_q.size()), 32'(0));
    obs_q.delete();
    release_req();

    // Held request must not restart
    start_op(3'b100, 0, 0, 2, 1, 16'h001F);
    push_fill(0, 0, 1, 0, 16'h001F);
    wait_done("hold", 3000, cyc);
    tick(50);
    check("hold done pulses", 32'(done_cnt), 32'(1));
    check("hold state", 32'(dbg_state), 32'(S_WAIT_REL));
    check("hold oCall", 32'(o_call), 32'(0));
    compare_log("hold", 1'b1);
    release_req();
    check("hold release state", 32'(dbg_state), 32'(S_IDLE));

    // Overlapping request: clear wins over fill; abort it with reset mid-PIX
    start_op(3'b110, 50, 60, 7, 7, 16'h1234);
`ifdef TFT_WINDOW_EN
    push_cmd(C_REG, 8'h44, 16'hEF00);
    push_cmd(C_REG, 8'h45, 16'h0000);
    push_cmd(C_REG, 8'h46, 16'h013F);
`endif
    push_cmd(C_REG, 8'h4E, 16'h0000);
    push_cmd(C_REG, 8'h4F, 16'h0000);
    push_cmd(C_IDX, 8'h22, 16'h0000);
    repeat (5) push_cmd(C_DATA, 8'h00, 16'h1234);
    cyc = 0;
    while (obs_q.size() < exp_q.size() && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("clear progress", 32'(obs_q.size() >= exp_q.size()), 32'(1));
    compare_log("clear", 1'b0);
    cyc = 0;
    while (o_call != C_DATA && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("clear in PIX", 32'(dbg_state), 32'(S_PIX));
    rst = 1'b1;
    i_call = 3'b000;
    @(negedge clk);
    check("abort oCall", 32'(o_call), 32'(0));
    check("abort oDone", 32'(o_done), 32'(0));
    check("abort state", 32'(dbg_state), 32'(S_IDLE));
    rst = 1'b0;
    tick(2);
    obs_q.delete();
    exp_q.delete();

    // Normal operation after the abort
    start_op(3'b100, 5, 6, 2, 2, 16'hABCD);
    push_fill(5, 6, 6, 7, 16'hABCD);
    wait_done("post-reset", 3000, cyc);
    compare_log("post-reset", 1'b1);
    release_req();
    check("post-reset done pulses", 32'(done_cnt), 32'(1));
    check("post-reset handshake", 32'(hs_viol), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
